// File: rtl/spram_arb_pkg.sv
// Shared types and helpers for the single-port RAM arbiter.
package spram_arb_pkg;

    localparam int MAX_REQ = 16;

    typedef logic [$clog2(MAX_REQ)-1:0] req_id_t;

    // Encode a one-hot (or zero) vector into the index of its set bit.
    function automatic req_id_t onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        req_id_t idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) idx = idx | req_id_t'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/spram_arbiter_rr_arbiter.sv
// Grant selection for the RAM arbiter. Round-robin with a rotating pointer
// when SPRAM_ARB_RR_EN is defined, otherwise fixed lowest-index priority.
module rr_arbiter
    import spram_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_advance,
    output logic [NUM_REQ-1:0] o_gnt
);

`ifdef SPRAM_ARB_RR_EN
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]   r_ptr;
    logic               w_found;
    logic [MAX_REQ-1:0] w_gnt_ext;
    req_id_t            w_gnt_idx;

    // First requester at or above ptr wins; otherwise first one below ptr.
    always_comb begin
        o_gnt   = '0;
        w_found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && i_req[i] && i >= int'(r_ptr)) begin
                o_gnt[i] = 1'b1;
                w_found  = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && i_req[i] && i < int'(r_ptr)) begin
                o_gnt[i] = 1'b1;
                w_found  = 1'b1;
            end
        end
        w_gnt_ext              = '0;
        w_gnt_ext[NUM_REQ-1:0] = o_gnt;
        w_gnt_idx              = onehot_to_idx(w_gnt_ext);
    end

    // Pointer moves just past the winner; idle cycles leave it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (i_advance) begin
            if (int'(w_gnt_idx) == NUM_REQ - 1) r_ptr <= '0;
            else                                r_ptr <= PTR_W'(int'(w_gnt_idx) + 1);
        end
    end
`else
    logic w_found;
    wire  w_unused = &{1'b0, clk, rst_n, i_advance};

    // Lowest-index requester wins.
    always_comb begin
        o_gnt   = '0;
        w_found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && i_req[i]) begin
                o_gnt[i] = 1'b1;
                w_found  = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/spram_arbiter.sv
// Shares one single-port RAM (1-cycle registered read) among NUM_REQ
// requesters. Issue is combinational in the grant cycle; read data comes
// back one cycle later tagged with a one-hot requester id.
// Build option: SPRAM_ARB_RR_EN selects round-robin instead of fixed priority.
module spram_arbiter
    import spram_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          mem_ena,
    output logic                          mem_wea,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_din,
    input  logic [DATA_WIDTH-1:0]         mem_dout
);

    logic [NUM_REQ-1:0] w_arb_gnt;
    logic               w_advance;
    logic [NUM_REQ-1:0] r_rsp_vld;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (req_valid),
        .i_advance (w_advance),
        .o_gnt     (w_arb_gnt)
    );

    // Grant is suppressed while reset is held; RAM port follows the winner.
    always_comb begin
        req_ready = w_arb_gnt & {NUM_REQ{rst_n}};
        w_advance = |req_ready;
        mem_ena   = |req_ready;
        mem_wea   = 1'b0;
        mem_addr  = '0;
        mem_din   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                mem_wea  = mem_wea  | req_we[i];
                mem_addr = mem_addr | req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                mem_din  = mem_din  | req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // One-hot id of the read issued last cycle; reset drops it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rsp_vld <= '0;
        else        r_rsp_vld <= req_ready & ~req_we;
    end

    // Read data is only presented alongside a response.
    always_comb begin
        rsp_valid = r_rsp_vld;
        rsp_data  = (|r_rsp_vld) ? mem_dout : '0;
    end

endmodule

// File: tb/tb_spram_arbiter.sv
// Bench for spram_arbiter: behavioural model + per-cycle compare, directed
// literal pins, then randomized traffic with occasional resets.
module tb_spram_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int AW = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_we = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_data;
    logic            mem_ena, mem_wea;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_din;
    logic [DW-1:0]   mem_dout = '0;

    int checks = 0;
    int errors = 0;

    spram_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .mem_ena(mem_ena),
        .mem_wea(mem_wea), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    // RAM seen by the DUT
    logic [DW-1:0] ram [2**AW];
    initial for (int i = 0; i < 2**AW; i++) ram[i] = '0;
    always @(posedge clk) begin
        if (mem_ena) begin
            if (mem_wea) ram[mem_addr] <= mem_din;
            else         mem_dout <= ram[mem_addr];
        end
    end

    // Reference model state
    logic [DW-1:0] m_mem [2**AW];
    initial for (int i = 0; i < 2**AW; i++) m_mem[i] = '0;
    int            m_ptr = 0;
    logic          m_pend = 1'b0;
    int            m_pend_id = 0;
    logic [DW-1:0] m_pend_data = '0;

    function automatic int model_grant(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
`ifdef SPRAM_ARB_RR_EN
            int idx = (p + k) % N;
`else
            int idx = k;
`endif
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model advance on each edge; reset clears pointer and pending read.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ptr  <= 0;
            m_pend <= 1'b0;
        end else begin
            int g;
            g = model_grant(req_valid, m_ptr);
            m_pend <= 1'b0;
            if (g >= 0) begin
                if (req_we[g]) begin
                    m_mem[req_addr[g*AW +: AW]] <= req_wdata[g*DW +: DW];
                end else begin
                    m_pend      <= 1'b1;
                    m_pend_id   <= g;
                    m_pend_data <= m_mem[req_addr[g*AW +: AW]];
                end
`ifdef SPRAM_ARB_RR_EN
                m_ptr <= (g + 1) % N;
`endif
            end
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        int g;
        g = rst_n ? model_grant(req_valid, m_ptr) : -1;
        chk("req_ready", 32'(req_ready), (g >= 0) ? 32'(1 << g) : 32'd0);
        chk("mem_ena",   32'(mem_ena),   32'(g >= 0));
        chk("mem_wea",   32'(mem_wea),   (g >= 0) ? 32'(req_we[g]) : 32'd0);
        chk("mem_addr",  32'(mem_addr),  (g >= 0) ? 32'(req_addr[g*AW +: AW]) : 32'd0);
        chk("mem_din",   32'(mem_din),   (g >= 0) ? 32'(req_wdata[g*DW +: DW]) : 32'd0);
        chk("rsp_valid", 32'(rsp_valid), m_pend ? 32'(1 << m_pend_id) : 32'd0);
        chk("rsp_data",  32'(rsp_data),  m_pend ? 32'(m_pend_data) : 32'd0);
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic at_check();
        @(negedge clk);
        #1;
    endtask

    logic [3:0] exp_rr  [8];
    logic [3:0] exp_033 [3];

    initial begin
        // reset state
        repeat (3) next_cycle();
        at_check();
        chk("lit_reset_ready", 32'(req_ready), 32'd0);
        chk("lit_reset_rsp",   32'(rsp_valid), 32'd0);
        chk("lit_reset_ena",   32'(mem_ena),   32'd0);
        next_cycle();
        rst_n = 1'b1;

        // all four requesting for 8 cycles
        req_valid = 4'b1111;
        for (int c = 0; c < 8; c++) begin
`ifdef SPRAM_ARB_RR_EN
            exp_rr[c] = 4'(1 << (c % 4));
`else
            exp_rr[c] = 4'b0001;
`endif
            at_check();
            chk("lit_all_valid", 32'(req_ready), 32'(exp_rr[c]));
            next_cycle();
        end

        // req 2 writes 0x5A @3, then req 0 reads @3
        req_valid = 4'b0100; req_we = 4'b0100;
        req_addr = '0; req_addr[2*AW +: AW] = 4'd3;
        req_wdata = '0; req_wdata[2*DW +: DW] = 8'h5A;
        at_check();
        chk("lit_wr_ena",  32'(mem_ena),  32'd1);
        chk("lit_wr_wea",  32'(mem_wea),  32'd1);
        chk("lit_wr_addr", 32'(mem_addr), 32'd3);
        chk("lit_wr_din",  32'(mem_din),  32'h5A);
        next_cycle();
        req_valid = 4'b0001; req_we = 4'b0000; req_addr = '0; req_addr[0 +: AW] = 4'd3;
        at_check();
        chk("lit_rd_ready", 32'(req_ready), 32'b0001);
        chk("lit_rd_rsp0",  32'(rsp_valid), 32'd0);
        next_cycle();
        req_valid = '0;
        at_check();
        chk("lit_rd_rsp",  32'(rsp_valid), 32'b0001);
        chk("lit_rd_data", 32'(rsp_data),  32'h5A);
        next_cycle();
        at_check();
        chk("lit_rd_rsp_once", 32'(rsp_valid), 32'd0);

        // 1010 for three cycles (RR pointer is 1 here)
`ifdef SPRAM_ARB_RR_EN
        exp_033[0] = 4'b0010; exp_033[1] = 4'b1000; exp_033[2] = 4'b0010;
`else
        exp_033[0] = 4'b0010; exp_033[1] = 4'b0010; exp_033[2] = 4'b0010;
`endif
        next_cycle();
        req_valid = 4'b1010;
        for (int c = 0; c < 3; c++) begin
            at_check();
            chk("lit_1010", 32'(req_ready), 32'(exp_033[c]));
            next_cycle();
        end

        // grant 2 (RR ptr -> 3), then 1001 twice
        req_valid = 4'b0100;
        at_check();
        chk("lit_g2", 32'(req_ready), 32'b0100);
        next_cycle();
        req_valid = 4'b1001;
        at_check();
`ifdef SPRAM_ARB_RR_EN
        chk("lit_wrap_a", 32'(req_ready), 32'b1000);
`else
        chk("lit_wrap_a", 32'(req_ready), 32'b0001);
`endif
        next_cycle();
        at_check();
        chk("lit_wrap_b", 32'(req_ready), 32'b0001);
        next_cycle();

        // idle 5 cycles, pointer must hold (RR ptr is 1)
        req_valid = '0;
        for (int c = 0; c < 5; c++) begin
            at_check();
            chk("lit_idle_ena",   32'(mem_ena),   32'd0);
            chk("lit_idle_ready", 32'(req_ready), 32'd0);
            next_cycle();
        end
        req_valid = 4'b1111;
        at_check();
`ifdef SPRAM_ARB_RR_EN
        chk("lit_idle_ptr", 32'(req_ready), 32'b0010);
`else
        chk("lit_idle_ptr", 32'(req_ready), 32'b0001);
`endif
        next_cycle();

        // read granted, reset pulse before the response edge
        req_valid = 4'b0001; req_we = '0; req_addr = '0; req_addr[0 +: AW] = 4'd5;
        at_check();
        chk("lit_rst_rd", 32'(req_ready), 32'b0001);
        #1;
        rst_n = 1'b0; req_valid = '0;
        next_cycle();
        rst_n = 1'b1;
        at_check();
        chk("lit_rst_drop", 32'(rsp_valid), 32'd0);
        next_cycle();
        req_valid = 4'b1111;
        at_check();
        chk("lit_rst_ptr", 32'(req_ready), 32'b0001);
        next_cycle();

        // randomized traffic
        for (int c = 0; c < 2000; c++) begin
            req_valid = 4'($urandom);
            req_we    = 4'($urandom);
            req_addr  = 16'($urandom);
            req_wdata = 32'($urandom);
            if ($urandom_range(0, 99) == 0) rst_n = 1'b0;
            else                            rst_n = 1'b1;
            next_cycle();
        end
        rst_n = 1'b1;
        req_valid = '0;
        next_cycle();
        at_check();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spram_arbiter.md
SPRAM_ARBITER -- requirements
Module: spram_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (1..16).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, RAM word width.
REQ-003 SHALL have parameter ADDR_WIDTH, default 4, RAM address width.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port req_valid  input  NUM_REQ  per-requester access request.
REQ-007 SHALL have port req_ready  output  NUM_REQ  per-requester grant/accept.
REQ-008 SHALL have port req_we  input  NUM_REQ  1 = write, 0 = read.
REQ-009 SHALL have port req_addr  input  NUM_REQ*ADDR_WIDTH  packed addresses, requester i at slice i.
REQ-010 SHALL have port req_wdata  input  NUM_REQ*DATA_WIDTH  packed write data.
REQ-011 SHALL have port rsp_valid  output  NUM_REQ  one-hot read-data-valid.
REQ-012 SHALL have port rsp_data  output  DATA_WIDTH  shared read data.
REQ-013 SHALL have ports mem_ena/mem_wea (output 1), mem_addr (output ADDR_WIDTH), mem_din (output DATA_WIDTH), mem_dout (input DATA_WIDTH): single-port RAM with 1-cycle registered read.

Function
REQ-014 SHALL grant at most one requester per cycle; req_ready is one-hot or zero, combinational from req_valid and arbitration state.
REQ-015 SHALL never assert req_ready[i] while req_valid[i]=0; transfer occurs when req_valid[i] & req_ready[i].
REQ-016 SHALL drive mem_ena=1, mem_wea=req_we[g], mem_addr/mem_din from granted slice g in the grant cycle (0-cycle issue latency).
REQ-017 SHALL drive mem_ena=0, mem_wea=0, mem_addr=0, mem_din=0 in cycles with no grant.
REQ-018 SHALL, for a granted read in cycle N, assert rsp_valid[g] for exactly cycle N+1 with rsp_data=mem_dout; rsp_data=0 when no rsp_valid.
REQ-019 SHALL produce no response for writes; a read after a write to the same address in the next cycle returns the new data.
REQ-020 SHALL sustain one access per cycle; back-to-back reads from different requesters yield back-to-back rsp_valid with correct one-hot id.
REQ-021 SHALL have no response backpressure; requesters accept rsp_valid unconditionally.
REQ-022 SHALL keep round-robin pointer ptr (width clog2(NUM_REQ), min 1): search starts at ptr, after grant to g ptr <= g+1 wrapping NUM_REQ-1 -> 0; no grant holds ptr.
REQ-023 SHALL, with NUM_REQ=1, grant requester 0 whenever req_valid[0]=1.

Reset
REQ-024 SHALL, while rst_n=0, force req_ready=0, rsp_valid=0, rsp_data=0, mem_ena=0, ptr=0, pending-read id cleared.
REQ-025 SHALL drop any in-flight read response when reset asserts mid-operation; no rsp_valid after release for pre-reset reads.
REQ-026 SHALL allow a grant in the first rising edge after rst_n deasserts.

Configuration
REQ-027 SHALL compile round-robin arbitration (REQ-022) when macro SPRAM_ARB_RR_EN is defined.
REQ-028 SHALL, without SPRAM_ARB_RR_EN, use fixed priority (lowest index wins) and contain no ptr register; all other behaviour identical.

Structure
REQ-029 SHALL place in package spram_arb_pkg: MAX_REQ constant, req id typedef, onehot-to-index function.
REQ-030 SHALL put grant selection and ptr in sub-module rr_arbiter (req vector in, one-hot grant out, advance strobe); datapath muxing and response tracking stay in spram_arbiter.

Verification
REQ-031 SHALL test: all 4 req_valid held high with RR, 8 cycles -> grants 0,1,2,3,0,1,2,3.
REQ-032 SHALL test: req 2 writes 0x5A to addr 3, next cycle req 0 reads addr 3 -> rsp_valid=4'b0001 one cycle later, rsp_data=0x5A.
REQ-033 SHALL test: without SPRAM_ARB_RR_EN, req_valid=4'b1010 for 3 cycles -> req_ready=4'b0010 every cycle.
REQ-034 SHALL test: ptr=3, req_valid=4'b1001 -> grant 3, then grant 0 (wrap).
REQ-035 SHALL test: read granted, rst_n low for 1 cycle before response edge -> rsp_valid stays 0, ptr=0 after release.
REQ-036 SHALL test: req_valid=0 for 5 cycles -> mem_ena=0, req_ready=0, ptr unchanged.
